// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared constants and types for the PS/2 key scanner: the PS/2 set-2
// prefix bytes, the frame length and the key-tracking state encoding.
package ps2_pkg;

  // Break (key release) prefix and extended-key prefix bytes.
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  // Start + 8 data + parity + stop.
  localparam int         FRAME_LEN = 11;
  localparam logic [3:0] STOP_IDX  = 4'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    BREAK   = 2'd2
  } key_state_t;

endpackage

// File: rtl/ps2_rx.sv
// ps2_rx
// PS/2 frame receiver. Synchronizes the raw PS/2 clock and data, detects
// falling edges of the PS/2 clock, assembles 11-bit frames, checks start,
// stop and odd parity, and discards a partial frame after a long idle gap.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   ps2_clk     raw PS/2 clock (asynchronous)
//   ps2_data    raw PS/2 data (asynchronous)
//   byte_valid  one-cycle pulse when a good frame completes
//   rx_byte     last good data byte, held until the next good frame
//   frame_err   one-cycle pulse when a frame fails start/stop/parity
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT_CYCLES);

  logic [2:0] clk_sync;   // [1:0] synchronizer, [2] previous sample for edge detect
  logic [1:0] data_sync;
  logic       fall_p0;
  logic       fall_p1;
  logic       data_p1;

  logic [3:0]  bitcnt;
  logic [9:0]  frame;     // start, data[7:0], parity; stop is checked on arrival
  logic [15:0] idle_cnt;
  logic        frame_good;

  // ---- stage p0: two-flop synchronizers plus edge history on ps2_clk ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= '0;
      data_sync <= '0;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign fall_p0 = clk_sync[2] & ~clk_sync[1];

  // ---- stage p1: registered edge strobe with its aligned data bit ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fall_p1 <= 1'b0;
      data_p1 <= 1'b0;
    end else begin
      fall_p1 <= fall_p0;
      data_p1 <= data_sync[1];
    end
  end

  // The stop bit is the bit arriving with this strobe, so it is taken
  // straight from data_p1 rather than stored into the frame.
  assign frame_good = ~frame[0] & data_p1 & (^frame[9:1]);

  // ---- stage p2: bit assembly, frame check and idle timeout ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitcnt     <= '0;
      frame      <= '0;
      idle_cnt   <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall_p1) begin
        // A falling edge always wins over a coincident timeout.
        idle_cnt <= '0;
        if (bitcnt == STOP_IDX) begin
          bitcnt <= '0;
          if (frame_good) begin
            byte_valid <= 1'b1;
            rx_byte    <= frame[8:1];
          end else begin
            frame_err  <= 1'b1;
          end
        end else begin
          frame[bitcnt] <= data_p1;
          bitcnt        <= bitcnt + 4'd1;
        end
      end else begin
        // Saturate so a long idle line never wraps back into a false timeout.
        if (idle_cnt != TIMEOUT_VAL) begin
          idle_cnt <= idle_cnt + 16'd1;
        end else if (bitcnt != '0) begin
          bitcnt <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/ps2_key_scanner.sv
// ps2_key_scanner
// Tracks make/break scan codes from a PS/2 keyboard and presents the held
// (or last) key code and a two-digit BCD press count as four nibbles for
// downstream seven-segment decoders.
//
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   ps2_clk     raw PS/2 clock
//   ps2_data    raw PS/2 data
//   byte_valid  one-cycle pulse per good received byte
//   rx_byte     last good received byte
//   frame_err   one-cycle pulse per bad frame
//   code_hi     upper nibble of the held/last scan code
//   code_lo     lower nibble of the held/last scan code
//   cnt_tens    BCD tens digit of the press count
//   cnt_ones    BCD ones digit of the press count
//   seg_en      high while a key is held (blanks code digits when low)
module ps2_key_scanner
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err,
  output logic [3:0] code_hi,
  output logic [3:0] code_lo,
  output logic [3:0] cnt_tens,
  output logic [3:0] cnt_ones,
  output logic       seg_en
);

  key_state_t state, state_nx;
  logic [7:0] code, code_nx;
  logic [7:0] count, count_nx;    // {tens, ones}
  logic       held, held_nx;

  // Two-digit BCD increment; 99 wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = v[7:4];
    ones = v[3:0];
    if (ones >= 4'd9) begin
      ones = 4'd0;
      tens = (tens >= 4'd9) ? 4'd0 : tens + 4'd1;
    end else begin
      ones = ones + 4'd1;
    end
    return {tens, ones};
  endfunction

  ps2_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_valid(byte_valid),
    .rx_byte   (rx_byte),
    .frame_err (frame_err)
  );

  // ---- stage p3: key tracking on each received byte ----
  always_comb begin
    state_nx = state;
    code_nx  = code;
    count_nx = count;
    held_nx  = held;
    // Extended prefix carries no key identity of its own and is ignored.
    if (byte_valid && (rx_byte != PS2_EXT)) begin
      case (state)
        IDLE: begin
          if (rx_byte == PS2_BREAK) begin
            state_nx = BREAK;
          end else begin
            code_nx  = rx_byte;
            count_nx = bcd_inc(count);
            held_nx  = 1'b1;
            state_nx = PRESSED;
          end
        end
        PRESSED: begin
          if (rx_byte == PS2_BREAK) begin
            state_nx = BREAK;
          end else if (rx_byte != code) begin
            // A byte equal to the held code is typematic repeat.
            code_nx  = rx_byte;
            count_nx = bcd_inc(count);
          end
        end
        BREAK: begin
          if (rx_byte == code) begin
            held_nx  = 1'b0;
            state_nx = IDLE;
          end else begin
            // Release of some other key: the held key is still down.
            state_nx = held ? PRESSED : IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      code  <= '0;
      count <= '0;
      held  <= 1'b0;
    end else begin
      state <= state_nx;
      code  <= code_nx;
      count <= count_nx;
      held  <= held_nx;
    end
  end

  assign code_hi  = code[7:4];
  assign code_lo  = code[3:0];
  assign cnt_tens = count[7:4];
  assign cnt_ones = count[3:0];
  assign seg_en   = held;

endmodule

// File: tb/tb_ps2_key_scanner.sv
module tb_ps2_key_scanner;

  localparam int TO = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       byte_valid;
  logic [7:0] rx_byte;
  logic       frame_err;
  logic [3:0] code_hi;
  logic [3:0] code_lo;
  logic [3:0] cnt_tens;
  logic [3:0] cnt_ones;
  logic       seg_en;

  ps2_key_scanner #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_valid(byte_valid),
    .rx_byte   (rx_byte),
    .frame_err (frame_err),
    .code_hi   (code_hi),
    .code_lo   (code_lo),
    .cnt_tens  (cnt_tens),
    .cnt_ones  (cnt_ones),
    .seg_en    (seg_en)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int half     = 4;

  // Pulse/sanity monitors.
  int bv_cnt = 0;
  int fe_cnt = 0;
  int both_cnt = 0;
  int over_cnt = 0;

  always @(negedge clk) begin
    if (byte_valid === 1'b1) bv_cnt <= bv_cnt + 1;
    if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
    if (byte_valid === 1'b1 && frame_err === 1'b1) both_cnt <= both_cnt + 1;
    if (cnt_tens > 4'd9 || cnt_ones > 4'd9) over_cnt <= over_cnt + 1;
  end

  // Reference model: which key is down, what was last pressed, how many presses.
  logic [7:0] m_rx;
  logic [7:0] m_code;
  bit         m_held;
  bit         m_after_break;
  int         m_count;

  function automatic void model_reset();
    m_rx = 8'h00; m_code = 8'h00; m_held = 0; m_after_break = 0; m_count = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    m_rx = b;
    if (b == 8'hE0) begin
      // prefix ignored
    end else if (m_after_break) begin
      m_after_break = 0;
      if (b == m_code) m_held = 0;
    end else if (b == 8'hF0) begin
      m_after_break = 1;
    end else if (!(m_held && b == m_code)) begin
      m_code  = b;
      m_held  = 1;
      m_count = (m_count + 1) % 100;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b, input bit bad);
    logic p;
    p = (~^b) ^ bad;
    return {1'b1, p, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ps2_data = f[i];
      repeat (half) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (half) @(negedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_rx_byte"}, 32'(rx_byte), 32'(m_rx));
    chk({tag, "_code_hi"}, 32'(code_hi), 32'(m_code[7:4]));
    chk({tag, "_code_lo"}, 32'(code_lo), 32'(m_code[3:0]));
    chk({tag, "_cnt_tens"}, 32'(cnt_tens), 32'(m_count / 10));
    chk({tag, "_cnt_ones"}, 32'(cnt_ones), 32'(m_count % 10));
    chk({tag, "_seg_en"}, 32'(seg_en), 32'(m_held));
  endtask

  task automatic send_byte(input string tag, input logic [7:0] b, input bit bad);
    int bv0, fe0;
    bv0 = bv_cnt;
    fe0 = fe_cnt;
    send_bits(mk(b, bad), 11);
    repeat (8) @(posedge clk);
    #1;
    if (!bad) model_byte(b);
    check_outputs(tag);
    chk({tag, "_bv_pulses"}, 32'(bv_cnt - bv0), bad ? 32'd0 : 32'd1);
    chk({tag, "_fe_pulses"}, 32'(fe_cnt - fe0), bad ? 32'd1 : 32'd0);
  endtask

  initial begin
    int fe_before;
    int r;
    logic [7:0] b;
    logic [7:0] pool [3];
    pool[0] = 8'h1C; pool[1] = 8'h32; pool[2] = 8'h45;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    chk("reset_bv", 32'(byte_valid), 32'd0);
    chk("reset_fe", 32'(frame_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Make code 0x1C with cycle-accurate latency checks around the stop bit
    send_bits(mk(8'h1C, 1'b0), 10);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (half) @(negedge clk);
    ps2_clk = 1'b0;
    @(posedge clk);            // edge 0
    @(posedge clk);            // edge 1
    @(posedge clk); #1;        // edge 2
    chk("lat_e2_bv", 32'(byte_valid), 32'd0);
    @(posedge clk); #1;        // edge 3
    chk("lat_e3_bv", 32'(byte_valid), 32'd1);
    chk("lat_e3_rx", 32'(rx_byte), 32'h1C);
    chk("lat_e3_seg", 32'(seg_en), 32'd0);
    chk("lat_e3_lo", 32'(code_lo), 32'd0);
    @(posedge clk); #1;        // edge 4
    chk("lat_e4_bv", 32'(byte_valid), 32'd0);
    chk("lat_e4_hi", 32'(code_hi), 32'h1);
    chk("lat_e4_lo", 32'(code_lo), 32'hC);
    chk("lat_e4_ones", 32'(cnt_ones), 32'd1);
    chk("lat_e4_seg", 32'(seg_en), 32'd1);
    repeat (half) @(negedge clk);
    ps2_clk = 1'b1;
    model_byte(8'h1C);
    repeat (4) @(posedge clk);
    #1;
    check_outputs("make");

    // Repeat, break, release
    send_byte("repeat", 8'h1C, 1'b0);
    send_byte("brk", 8'hF0, 1'b0);
    send_byte("release", 8'h1C, 1'b0);
    chk("release_seg", 32'(seg_en), 32'd0);
    chk("release_ones", 32'(cnt_ones), 32'd1);
    chk("release_lo", 32'(code_lo), 32'hC);

    // Parity error
    send_byte("parity", 8'h1C, 1'b1);

    // Timeout on a partial frame, then a clean 0x32
    fe_before = fe_cnt;
    send_bits(mk(8'h32, 1'b0), 5);
    repeat (TO + 5) @(negedge clk);
    send_byte("timeout", 8'h32, 1'b0);
    chk("timeout_hi", 32'(code_hi), 32'h3);
    chk("timeout_lo", 32'(code_lo), 32'h2);
    chk("timeout_no_fe", 32'(fe_cnt - fe_before), 32'd0);

    // Reset mid-frame
    send_bits(mk(8'h77, 1'b0), 6);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("rstmid");
    chk("rstmid_bv", 32'(byte_valid), 32'd0);
    chk("rstmid_fe", 32'(frame_err), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send_byte("after_rst", 8'h45, 1'b0);
    chk("after_rst_hi", 32'(code_hi), 32'h4);
    chk("after_rst_ones", 32'(cnt_ones), 32'd1);
    send_byte("rel45_f0", 8'hF0, 1'b0);
    send_byte("rel45", 8'h45, 1'b0);

    // BCD wrap: count is 1, so 98 more presses reach 99
    for (int k = 0; k < 98; k++) begin
      send_byte("wrap_press", 8'h1C, 1'b0);
      send_byte("wrap_f0", 8'hF0, 1'b0);
      send_byte("wrap_rel", 8'h1C, 1'b0);
    end
    chk("wrap99_tens", 32'(cnt_tens), 32'd9);
    chk("wrap99_ones", 32'(cnt_ones), 32'd9);
    send_byte("wrap_press", 8'h1C, 1'b0);
    chk("wrap00_tens", 32'(cnt_tens), 32'd0);
    chk("wrap00_ones", 32'(cnt_ones), 32'd0);
    send_byte("wrap_f0", 8'hF0, 1'b0);
    send_byte("wrap_rel", 8'h1C, 1'b0);
    send_byte("wrap_press", 8'h1C, 1'b0);
    chk("wrap01_tens", 32'(cnt_tens), 32'd0);
    chk("wrap01_ones", 32'(cnt_ones), 32'd1);

    // Randomized traffic against the model
    for (int k = 0; k < 70; k++) begin
      half = $urandom_range(3, 7);
      r = $urandom_range(0, 9);
      if (r <= 2)      b = 8'hF0;
      else if (r == 3) b = 8'hE0;
      else if (r <= 7) b = pool[$urandom_range(0, 2)];
      else             b = 8'($urandom_range(0, 255));
      send_byte("rand", b, (r == 9));
    end

    chk("never_both_pulses", 32'(both_cnt), 32'd0);
    chk("digits_le_9", 32'(over_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
